// File: rtl/multi_op_calc_pkg.sv
// Shared definitions for the multi-op calculator: opcodes, FSM states and
// result-width helpers used by the top, the multiplier and the bus interface.
package multi_op_calc_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_ACC = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_B  = 2'd1,
    MUL_RUN = 2'd2,
    OUT     = 2'd3
  } state_t;

  function automatic int res_width(input int width);
    return 2 * width;
  endfunction

  // ACC and CLR complete on a single capture; every other op needs a B operand.
  function automatic logic is_single_operand(input logic [2:0] op);
    return (op == OP_ACC) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/multi_op_calc_if.sv
// Operand/result bus of the calculator. The stimulus side is the master,
// the calculator itself is the slave.
interface multi_op_calc_if import multi_op_calc_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int RES_W = res_width(WIDTH);

  logic [WIDTH-1:0] d_in;
  logic [2:0]       op;
  logic             capture;
  logic             busy;
  logic             valid;
  logic [RES_W-1:0] result;

  modport master (
    output d_in, op, capture,
    input  busy, valid, result
  );

  modport slave (
    input  d_in, op, capture,
    output busy, valid, result
  );
endinterface

// File: rtl/multi_op_calc_shift_add_mul.sv
// Iterative unsigned multiplier: one shift-add step per cycle, LSB of b first,
// WIDTH steps after a start pulse.
module shift_add_mul import multi_op_calc_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  output logic                           busy,
  output logic                           done,
  output logic [res_width(WIDTH)-1:0]    product
);
  localparam int RES_W = res_width(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [RES_W-1:0] mcand;
  logic [RES_W-1:0] prod;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= RES_W'(a);
      prod   <= '0;
      mplier <= b;
      count  <= CNT_W'(WIDTH);
    end else if (count != '0) begin
      if (mplier[0]) begin
        prod <= prod + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CNT_W'(1);
    end
  end

  // done flags the cycle of the final step, so product is complete on the
  // same edge that moves the caller out of its wait state.
  assign busy    = (count != '0);
  assign done    = (count == CNT_W'(1));
  assign product = prod;

endmodule

// File: rtl/multi_op_calc.sv
// Eight-op capture calculator: ALU mux, persistent accumulator and the control
// FSM; multiplication is delegated to the shift-add sub-module.
module multi_op_calc import multi_op_calc_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  multi_op_calc_if.slave  bus
);
  localparam int RES_W = res_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] alu_out;
  logic [RES_W-1:0] result_reg;
  logic             valid_reg;
  logic             load_a;
  logic             load_b;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [RES_W-1:0] mul_product;
  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a_reg),
    .b       (bus.d_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The valid cycle is spent in IDLE but still counts as busy, so a capture
  // arriving alongside valid is dropped rather than starting a new op.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.capture && !valid_reg) begin
          state_next = is_single_operand(bus.op) ? OUT : WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.capture) begin
          state_next = (op_reg == OP_MUL) ? MUL_RUN : OUT;
        end
      end
      MUL_RUN: begin
        if (mul_done) begin
          state_next = OUT;
        end
      end
      OUT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_a    = 1'b0;
    load_b    = 1'b0;
    mul_start = 1'b0;
    unique case (state)
      IDLE:    load_a = bus.capture && !valid_reg;
      WAIT_B: begin
        load_b    = bus.capture;
        mul_start = bus.capture && (op_reg == OP_MUL);
      end
      default: ;
    endcase
  end

  assign a_ext = RES_W'(a_reg);
  assign b_ext = RES_W'(b_reg);

  always_comb begin
    alu_out = '0;
    unique case (op_reg)
      OP_ADD: alu_out = a_ext + b_ext;
      OP_SUB: alu_out = a_ext - b_ext;
      OP_AND: alu_out = a_ext & b_ext;
      OP_OR:  alu_out = a_ext | b_ext;
      OP_XOR: alu_out = a_ext ^ b_ext;
      OP_MUL: alu_out = mul_product;
      OP_ACC: alu_out = acc + a_ext;
      OP_CLR: alu_out = '0;
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (load_a) begin
        a_reg  <= bus.d_in;
        op_reg <= bus.op;
      end
      if (load_b) begin
        b_reg <= bus.d_in;
      end
      if (state == OUT) begin
        valid_reg  <= 1'b1;
        result_reg <= alu_out;
        if (is_single_operand(op_reg)) begin
          acc <= alu_out;
        end
      end
    end
  end

  assign bus.busy   = (state != IDLE) || valid_reg || mul_busy;
  assign bus.valid  = valid_reg;
  assign bus.result = result_reg;

endmodule

// File: tb/tb_multi_op_calc.sv
// Scoreboard bench for multi_op_calc: stimulus pushes expected results and
// latencies, a negedge monitor pops and compares on every valid pulse.
module tb_multi_op_calc;
  import multi_op_calc_pkg::*;

  localparam int WIDTH = 4;

  typedef struct {
    int res;
    int edge_n;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   done_count = 0;
  int   acc_m = 0;
  int   last_result = 0;
  exp_t sb[$];

  multi_op_calc_if #(.WIDTH(WIDTH)) bus ();

  multi_op_calc #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: plain 8-bit arithmetic on the operand values.
  function automatic int model(input logic [2:0] o, input int a, input int b);
    case (o)
      OP_ADD: return (a + b) % 256;
      OP_SUB: return (a - b + 256) % 256;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_MUL: return a * b;
      OP_ACC: begin
        acc_m = (acc_m + a) % 256;
        return acc_m;
      end
      default: begin
        acc_m = 0;
        return 0;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_result = 0;
    end else if (bus.valid) begin
      done_count++;
      check_output("busy_during_valid", int'(bus.busy), 1);
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_valid: got result %0d, expected no valid (cycle %0d)", bus.result, cyc);
      end else begin
        e = sb.pop_front();
        check_output("result", int'(bus.result), e.res);
        check_output("latency", cyc - e.edge_n, e.lat);
      end
      last_result = int'(bus.result);
    end else begin
      check_output("result_held", int'(bus.result), last_result);
    end
  end

  task automatic drive_capture(input logic [2:0] o, input logic [3:0] d, input bit keep,
                               output int edge_n);
    @(negedge clk);
    bus.capture = 1'b1;
    bus.op      = o;
    bus.d_in    = d;
    edge_n      = cyc + 1;
    @(negedge clk);
    if (!keep) bus.capture = 1'b0;
  endtask

  task automatic expect_and_wait(input exp_t e);
    int  start;
    bit  seen;
    start = done_count;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      if (done_count > start) seen = 1'b1;
    end
    check_output("completion", int'(seen), 1);
    @(negedge clk);
    bus.capture = 1'b0;
    check_output("busy_after_valid", int'(bus.busy), 0);
  endtask

  // hold keeps capture asserted through MUL_RUN, OUT and the valid cycle.
  task automatic apply_stimulus(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                                input bit hold);
    exp_t e;
    int   n;
    if (o == OP_ACC || o == OP_CLR) begin
      drive_capture(o, a, hold, n);
    end else begin
      drive_capture(o, a, 1'b0, n);
      drive_capture(3'($urandom_range(0, 7)), b, hold, n);
    end
    e.res    = model(o, int'(a), int'(b));
    e.edge_n = n;
    e.lat    = (o == OP_MUL) ? WIDTH + 1 : 1;
    expect_and_wait(e);
  endtask

  initial begin
    exp_t e;
    int   n;
    rst         = 1'b1;
    bus.capture = 1'b0;
    bus.op      = 3'b000;
    bus.d_in    = '0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", int'(bus.busy), 0);
    check_output("reset_valid", int'(bus.valid), 0);
    check_output("reset_result", int'(bus.result), 0);
    rst = 1'b0;

    apply_stimulus(OP_ADD, 4'd9, 4'd7, 1'b0);
    apply_stimulus(OP_SUB, 4'd3, 4'd5, 1'b0);
    apply_stimulus(OP_XOR, 4'hA, 4'h6, 1'b0);
    apply_stimulus(OP_MUL, 4'd15, 4'd15, 1'b1);
    apply_stimulus(OP_ADD, 4'd9, 4'd7, 1'b1);
    apply_stimulus(OP_ACC, 4'd5, 4'd0, 1'b0);
    apply_stimulus(OP_ACC, 4'd10, 4'd0, 1'b0);
    apply_stimulus(OP_CLR, 4'd9, 4'd0, 1'b0);
    apply_stimulus(OP_ACC, 4'd3, 4'd0, 1'b1);
    for (int i = 0; i < 200; i++) apply_stimulus(OP_ACC, 4'd15, 4'd0, 1'b0);

    // Reset in the middle of a multiply must abort it silently.
    apply_stimulus(OP_ACC, 4'd7, 4'd0, 1'b0);
    drive_capture(OP_MUL, 4'd15, 1'b0, n);
    drive_capture(OP_ADD, 4'd15, 1'b0, n);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_mul_busy", int'(bus.busy), 0);
    check_output("rst_mul_valid", int'(bus.valid), 0);
    check_output("rst_mul_result", int'(bus.result), 0);
    rst   = 1'b0;
    acc_m = 0;
    repeat (10) @(negedge clk);
    apply_stimulus(OP_ACC, 4'd3, 4'd0, 1'b0);

    // Long stall in WAIT_B, then the B capture finishes the op.
    drive_capture(OP_OR, 4'd5, 1'b0, n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("wait_b_busy", int'(bus.busy), 1);
    end
    drive_capture(OP_AND, 4'd12, 1'b0, n);
    e.res    = model(OP_OR, 5, 12);
    e.edge_n = n;
    e.lat    = 1;
    expect_and_wait(e);

    for (int i = 0; i < 150; i++) begin
      apply_stimulus(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check_output("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
